dctlb_ptn: RTL and testbench
============================

# dctlb_ptn

Parametrised multi-channel L1 data-TLB front end, the successor to the two-port passthrough DCTLB.
- Sits between the core load/store ports, the L1 prefetcher and the L1 D-cache forward ports.
- Buffers NCH request channels in per-channel FIFOs and opportunistically injects L1 prefetches into idle channels (round-robin).
- Computes hashed hpaddr/ppaddr and a canonical-address fault, and relays L2TLB snoops to the L1 as commands, acknowledging back to the L2TLB.

## Interface
Parameters:
- NCH, 2, number of core request / forward channel pairs (1..8)
- DEPTH, 2, entries per channel FIFO (power of 2, ≥2)
- LADDR_W, 39, logical address width
- CANON_W, 32, implemented VA bits; bits above must sign-extend bit CANON_W-1
- HPADDR_W, 11, hashed paddr width
- PPADDR_W, 3, ppaddr width
- COREID_W, 6, core id width

Ports (flat vectors; channel i occupies slice i):
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- core_valid  in  NCH  core request valid per channel
- core_retry  out  NCH  core request retry
- core_laddr  in  NCH*LADDR_W  request address
- core_coreid  in  NCH*COREID_W  request core id
- pfe_valid  in  1  prefetch request valid
- pfe_retry  out  1  prefetch retry
- pfe_laddr  in  LADDR_W  prefetch address
- pfe_l2  in  1  prefetch targets L2 only
- fwd_valid  out  NCH  forward valid
- fwd_retry  in  NCH  forward retry
- fwd_coreid  out  NCH*COREID_W  forwarded core id
- fwd_prefetch  out  NCH  entry is a prefetch
- fwd_fault  out  NCH  non-canonical address
- fwd_hpaddr  out  NCH*HPADDR_W  hashed paddr
- fwd_ppaddr  out  NCH*PPADDR_W  ppaddr
- snoop_valid  in  1  L2TLB snoop valid
- snoop_retry  out  1  snoop retry
- snoop_hpaddr  in  HPADDR_W  displaced entry
- cmd_valid  out  1  L1 invalidate command valid
- cmd_retry  in  1  L1 command retry
- cmd_hpaddr  out  HPADDR_W  hpaddr to invalidate
- sack_valid  out  1  snoop ack to L2TLB
- sack_retry  in  1  ack retry
- sack_hpaddr  out  HPADDR_W  acknowledged hpaddr

## Operation
- Handshake: a transfer occurs on a cycle with valid=1 and retry=0. A sender holds valid and payload stable while retry=1.
- Translation, combinational on enqueue and stored in the FIFO:
  - ppaddr = laddr[12+PPADDR_W-1:12].
  - hpaddr = XOR-fold of laddr[LADDR_W-1:12] in HPADDR_W-bit chunks; the top chunk is zero-padded.
  - fault = 1 if laddr[LADDR_W-1:CANON_W] is not all equal to laddr[CANON_W-1].
  - Faulting requests are still forwarded.
- Channel i enqueue:
  - core_retry[i] = FIFO i full. Retry is independent of fwd_retry; a full FIFO does not allow pass-through even when dequeuing in the same cycle.
  - Core requests have priority over prefetch on their channel.
- Prefetch:
  - pfe_l2=1: accepted whenever pfe_valid and dropped (pfe_retry=0). The block is L1-only.
  - pfe_l2=0: eligible channel = core_valid[i]=0 and FIFO i not full. The winner is chosen round-robin starting from the pointer rr.
  - On accept, rr = winner+1 mod NCH; otherwise rr is unchanged.
  - pfe_retry = no eligible channel. A prefetch enqueue carries coreid=0 and prefetch=1.
- Snoop FSM:
  - IDLE: snoop_retry=0. On accept, latch hpaddr and go to CMD.
  - CMD: cmd_valid=1, snoop_retry=1. When the command is accepted, go to SACK.
  - SACK: sack_valid=1, snoop_retry=1. When the ack is accepted, go to IDLE.
  - The FSM is independent of the request channels.

## Timing
- Reset (reset=0 at a clk edge):
  - FIFOs empty, rr=0, FSM=IDLE.
  - All valid outputs 0; core_retry=0; pfe_retry=0; snoop_retry=0.
  - Payload outputs 0.
- Latency: enqueue at edge N → fwd_valid=1 in cycle N+1. Outputs are registered FIFO heads with no combinational input→output path.
- Throughput: 1 request/cycle/channel while downstream accepts, since DEPTH≥2.
- Simultaneous enqueue and dequeue on a non-full FIFO: both occur and the count is unchanged.
- Pointer wrap: read/write pointers are log2(DEPTH)+1 bits. Full = MSBs differ and lower bits equal.
- Snoop round trip: minimum 3 cycles (accept → cmd → sack). A back-to-back snoop is accepted in the cycle after the sack transfer.
- Reset mid-operation drops all queued entries and any in-flight snoop without acking it.

## Test plan
- Single request: NCH=2, core_valid[0], laddr=0x0000_1234_5000, coreid=3 → next cycle fwd_valid[0]=1, coreid=3, prefetch=0, fault=0, ppaddr=5, hpaddr = fold value from the bench model.
- Backpressure: hold fwd_retry[1]=1 and issue 3 requests on channel 1 → first 2 accepted, core_retry[1]=1 on the third. Release retry → in-order drain, one per cycle.
- Prefetch round-robin with both cores idle:
  - 4 prefetches with l2=0 → channels 0,1,0,1.
  - With core_valid[0]=1, the prefetch goes to channel 1.
  - With l2=1, accepted and nothing forwarded.
- Fault: laddr=0x00_8000_0000 with CANON_W=32 → fault=1. Sign-extended 0x7F_FFFF_FFFF → fault=0.
- Snoop: snoop hpaddr=0x2A with cmd_retry=1 for 2 cycles → cmd held; after release, sack_hpaddr=0x2A; snoop_retry=1 until the sack transfer. Reset asserted in SACK → all valids 0 next cycle.

Source files
------------

// File: rtl/dctlb_ptn.sv
// rtl/dctlb_ptn.sv - multi-channel L1 data-TLB front end
// Per-channel request FIFOs with round-robin prefetch injection, plus an L2TLB snoop relay FSM.
module dctlb_ptn #(
  parameter int NCH      = 2,
  parameter int DEPTH    = 2,
  parameter int LADDR_W  = 39,
  parameter int CANON_W  = 32,
  parameter int HPADDR_W = 11,
  parameter int PPADDR_W = 3,
  parameter int COREID_W = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NCH-1:0]               core_valid,
  output logic [NCH-1:0]               core_retry,
  input  logic [NCH*LADDR_W-1:0]       core_laddr,
  input  logic [NCH*COREID_W-1:0]      core_coreid,
  input  logic                         pfe_valid,
  output logic                         pfe_retry,
  input  logic [LADDR_W-1:0]           pfe_laddr,
  input  logic                         pfe_l2,
  output logic [NCH-1:0]               fwd_valid,
  input  logic [NCH-1:0]               fwd_retry,
  output logic [NCH*COREID_W-1:0]      fwd_coreid,
  output logic [NCH-1:0]               fwd_prefetch,
  output logic [NCH-1:0]               fwd_fault,
  output logic [NCH*HPADDR_W-1:0]      fwd_hpaddr,
  output logic [NCH*PPADDR_W-1:0]      fwd_ppaddr,
  input  logic                         snoop_valid,
  output logic                         snoop_retry,
  input  logic [HPADDR_W-1:0]          snoop_hpaddr,
  output logic                         cmd_valid,
  input  logic                         cmd_retry,
  output logic [HPADDR_W-1:0]          cmd_hpaddr,
  output logic                         sack_valid,
  input  logic                         sack_retry,
  output logic [HPADDR_W-1:0]          sack_hpaddr
);
  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;
  localparam int RRW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int UW     = LADDR_W - 12;
  localparam int NCHUNK = (UW + HPADDR_W - 1) / HPADDR_W;
  localparam int PADW   = NCHUNK * HPADDR_W;

  typedef struct packed {
    logic [COREID_W-1:0] coreid;
    logic                prefetch;
    logic                fault;
    logic [HPADDR_W-1:0] hpaddr;
    logic [PPADDR_W-1:0] ppaddr;
  } ent_t;

  // Translation happens on enqueue so the FIFO head drives the outputs directly.
  function automatic ent_t xlate(input logic [LADDR_W-1:0] a,
                                 input logic [COREID_W-1:0] id,
                                 input logic pf);
    ent_t e;
    logic [PADW-1:0] pad;
    e          = '0;
    e.coreid   = id;
    e.prefetch = pf;
    e.ppaddr   = a[12+PPADDR_W-1:12];
    e.fault    = (a != LADDR_W'($signed(a[CANON_W-1:0])));
    pad        = PADW'(a[LADDR_W-1:12]);
    for (int c = 0; c < NCHUNK; c++) begin
      e.hpaddr = e.hpaddr ^ pad[HPADDR_W-1:0];
      pad      = pad >> HPADDR_W;
    end
    return e;
  endfunction

  logic [NCH-1:0] full, empty, enq, deq, elig, pf_grant_raw, pf_grant;
  logic [RRW-1:0] rr_q, rr_d, rr_next;
  logic           pf_found, pf_acc;

  always_comb begin
    pf_found     = 1'b0;
    pf_grant_raw = '0;
    rr_next      = rr_q;
    elig         = ~core_valid & ~full;
    for (int i = 0; i < NCH; i++) begin
      if (!pf_found && elig[i] && RRW'(i) >= rr_q) begin
        pf_found        = 1'b1;
        pf_grant_raw[i] = 1'b1;
        rr_next         = (i == NCH - 1) ? '0 : RRW'(i + 1);
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (!pf_found && elig[i] && RRW'(i) < rr_q) begin
        pf_found        = 1'b1;
        pf_grant_raw[i] = 1'b1;
        rr_next         = (i == NCH - 1) ? '0 : RRW'(i + 1);
      end
    end
  end

  assign pf_acc     = pfe_valid && !pfe_l2 && pf_found;
  assign pf_grant   = pf_acc ? pf_grant_raw : '0;
  assign pfe_retry  = pfe_valid && !pfe_l2 && !pf_found;
  assign rr_d       = pf_acc ? rr_next : rr_q;
  assign enq        = (core_valid & ~full) | pf_grant;
  assign core_retry = full;

  always_ff @(posedge clk) begin
    if (!reset) rr_q <= '0;
    else        rr_q <= rr_d;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ent_t           mem_q [DEPTH];
    logic [PW-1:0]  wr_q, rd_q;
    ent_t           enq_ent, head;

    assign full[i]  = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty[i] = (wr_q == rd_q);
    assign deq[i]   = !empty[i] && !fwd_retry[i];
    assign enq_ent  = core_valid[i]
                    ? xlate(core_laddr[i*LADDR_W +: LADDR_W], core_coreid[i*COREID_W +: COREID_W], 1'b0)
                    : xlate(pfe_laddr, '0, 1'b1);
    assign head     = empty[i] ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
      if (!reset) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (enq[i]) begin
          mem_q[wr_q[AW-1:0]] <= enq_ent;
          wr_q                <= wr_q + 1'b1;
        end
        if (deq[i]) rd_q <= rd_q + 1'b1;
      end
    end

    assign fwd_valid[i]                          = !empty[i];
    assign fwd_coreid[i*COREID_W +: COREID_W]    = head.coreid;
    assign fwd_prefetch[i]                       = head.prefetch;
    assign fwd_fault[i]                          = head.fault;
    assign fwd_hpaddr[i*HPADDR_W +: HPADDR_W]    = head.hpaddr;
    assign fwd_ppaddr[i*PPADDR_W +: PPADDR_W]    = head.ppaddr;
  end

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_SACK} snp_state_e;
  snp_state_e          state_q, state_d;
  logic [HPADDR_W-1:0] snp_hp_q, snp_hp_d;

  always_comb begin
    state_d     = state_q;
    snp_hp_d    = snp_hp_q;
    snoop_retry = 1'b1;
    cmd_valid   = 1'b0;
    sack_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        snoop_retry = 1'b0;
        if (snoop_valid) begin
          snp_hp_d = snoop_hpaddr;
          state_d  = S_CMD;
        end
      end
      S_CMD: begin
        cmd_valid = 1'b1;
        if (!cmd_retry) state_d = S_SACK;
      end
      S_SACK: begin
        sack_valid = 1'b1;
        if (!sack_retry) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      snp_hp_q <= '0;
    end else begin
      state_q  <= state_d;
      snp_hp_q <= snp_hp_d;
    end
  end

  assign cmd_hpaddr  = snp_hp_q;
  assign sack_hpaddr = snp_hp_q;
endmodule

// File: tb/tb_dctlb_ptn.sv
// tb/tb_dctlb_ptn.sv - directed self-checking bench for dctlb_ptn
// Expected hpaddr values are hand-folded from the stimulus addresses.
module tb_dctlb_ptn;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  core_valid, core_retry;
  logic [77:0] core_laddr;
  logic [11:0] core_coreid;
  logic        pfe_valid, pfe_retry, pfe_l2;
  logic [38:0] pfe_laddr;
  logic [1:0]  fwd_valid, fwd_retry, fwd_prefetch, fwd_fault;
  logic [11:0] fwd_coreid;
  logic [21:0] fwd_hpaddr;
  logic [5:0]  fwd_ppaddr;
  logic        snoop_valid, snoop_retry, cmd_valid, cmd_retry, sack_valid, sack_retry;
  logic [10:0] snoop_hpaddr, cmd_hpaddr, sack_hpaddr;

  int total = 0;
  int bad   = 0;

  dctlb_ptn dut (
    .clk(clk), .reset(reset),
    .core_valid(core_valid), .core_retry(core_retry), .core_laddr(core_laddr), .core_coreid(core_coreid),
    .pfe_valid(pfe_valid), .pfe_retry(pfe_retry), .pfe_laddr(pfe_laddr), .pfe_l2(pfe_l2),
    .fwd_valid(fwd_valid), .fwd_retry(fwd_retry), .fwd_coreid(fwd_coreid), .fwd_prefetch(fwd_prefetch),
    .fwd_fault(fwd_fault), .fwd_hpaddr(fwd_hpaddr), .fwd_ppaddr(fwd_ppaddr),
    .snoop_valid(snoop_valid), .snoop_retry(snoop_retry), .snoop_hpaddr(snoop_hpaddr),
    .cmd_valid(cmd_valid), .cmd_retry(cmd_retry), .cmd_hpaddr(cmd_hpaddr),
    .sack_valid(sack_valid), .sack_retry(sack_retry), .sack_hpaddr(sack_hpaddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; core_valid = '0; core_laddr = '0; core_coreid = '0;
    pfe_valid = 1'b0; pfe_laddr = '0; pfe_l2 = 1'b0; fwd_retry = '0;
    snoop_valid = 1'b0; snoop_hpaddr = '0; cmd_retry = 1'b0; sack_retry = 1'b0;
    tick; tick;
    chk("rst_fwd_valid", 64'(fwd_valid), 0);
    chk("rst_core_retry", 64'(core_retry), 0);
    chk("rst_pfe_retry", 64'(pfe_retry), 0);
    chk("rst_snoop_retry", 64'(snoop_retry), 0);
    chk("rst_cmd_sack", 64'({cmd_valid, sack_valid}), 0);
    chk("rst_payload", 64'({fwd_hpaddr, fwd_ppaddr, fwd_coreid}), 0);
    reset = 1'b1;
    tick;

    // single request on channel 0
    core_valid = 2'b01; core_laddr[38:0] = 39'h00_1234_5000; core_coreid[5:0] = 6'd3;
    tick;
    core_valid = '0;
    chk("single_valid", 64'(fwd_valid), 64'h1);
    chk("single_coreid", 64'(fwd_coreid[5:0]), 3);
    chk("single_prefetch", 64'(fwd_prefetch[0]), 0);
    chk("single_fault", 64'(fwd_fault[0]), 0);
    chk("single_ppaddr", 64'(fwd_ppaddr[2:0]), 5);
    chk("single_hpaddr", 64'(fwd_hpaddr[10:0]), 64'h361);
    tick;
    chk("single_drained", 64'(fwd_valid), 0);

    // backpressure on channel 1
    fwd_retry = 2'b10;
    core_valid = 2'b10; core_laddr[77:39] = 39'h1000; core_coreid[11:6] = 6'd1;
    #1 chk("bp_retry_1", 64'(core_retry[1]), 0);
    tick;
    core_laddr[77:39] = 39'h2000; core_coreid[11:6] = 6'd2;
    #1 chk("bp_retry_2", 64'(core_retry[1]), 0);
    tick;
    core_laddr[77:39] = 39'h3000; core_coreid[11:6] = 6'd3;
    #1 chk("bp_retry_3", 64'(core_retry[1]), 1);
    tick;
    fwd_retry = 2'b00;
    chk("bp_still_full", 64'(core_retry[1]), 1);
    chk("bp_head1", 64'(fwd_coreid[11:6]), 1);
    tick;
    chk("bp_head2", 64'(fwd_coreid[11:6]), 2);
    chk("bp_room", 64'(core_retry[1]), 0);
    tick;
    core_valid = '0;
    chk("bp_head3_id", 64'(fwd_coreid[11:6]), 3);
    chk("bp_head3_pp", 64'(fwd_ppaddr[5:3]), 3);
    chk("bp_head3_hp", 64'(fwd_hpaddr[21:11]), 3);
    tick;
    chk("bp_drained", 64'(fwd_valid), 0);

    // prefetch round-robin, both cores idle
    fwd_retry = 2'b11;
    pfe_valid = 1'b1; pfe_l2 = 1'b0;
    for (int k = 4; k < 8; k++) begin
      pfe_laddr = 39'(k) << 12;
      #1 chk("pf_accept", 64'(pfe_retry), 0);
      tick;
    end
    pfe_laddr = 39'h8000;
    #1 chk("pf_all_full", 64'(pfe_retry), 1);
    pfe_valid = 1'b0;
    chk("pf_valid", 64'(fwd_valid), 64'h3);
    chk("pf_flag", 64'(fwd_prefetch), 64'h3);
    chk("pf_coreid", 64'(fwd_coreid), 0);
    chk("pf_ch0_first", 64'(fwd_ppaddr[2:0]), 4);
    chk("pf_ch1_first", 64'(fwd_ppaddr[5:3]), 5);
    fwd_retry = 2'b00;
    tick;
    chk("pf_ch0_second", 64'(fwd_ppaddr[2:0]), 6);
    chk("pf_ch1_second", 64'(fwd_ppaddr[5:3]), 7);
    tick;
    chk("pf_drained", 64'(fwd_valid), 0);

    // core 0 busy: prefetch must land on channel 1
    core_valid = 2'b01; core_laddr[38:0] = 39'h0; core_coreid[5:0] = 6'd9;
    pfe_valid = 1'b1; pfe_laddr = 39'h1000;
    tick;
    core_valid = '0; pfe_valid = 1'b0;
    chk("pfc_valid", 64'(fwd_valid), 64'h3);
    chk("pfc_prefetch", 64'(fwd_prefetch), 64'h2);
    chk("pfc_ch1_pp", 64'(fwd_ppaddr[5:3]), 1);
    chk("pfc_ch0_id", 64'(fwd_coreid[5:0]), 9);
    tick;

    // L2-only prefetch is dropped
    pfe_valid = 1'b1; pfe_l2 = 1'b1; pfe_laddr = 39'h5000;
    #1 chk("l2_no_retry", 64'(pfe_retry), 0);
    tick;
    pfe_valid = 1'b0; pfe_l2 = 1'b0;
    chk("l2_nothing_fwd", 64'(fwd_valid), 0);

    // canonical fault check
    core_valid = 2'b11;
    core_laddr = {39'h7F_FFFF_FFFF, 39'h00_8000_0000};
    core_coreid = '0;
    tick;
    core_valid = '0;
    chk("fault_set", 64'(fwd_fault[0]), 1);
    chk("fault_hp0", 64'(fwd_hpaddr[10:0]), 64'h100);
    chk("fault_clear", 64'(fwd_fault[1]), 0);
    chk("fault_hp1", 64'(fwd_hpaddr[21:11]), 64'h1F);
    chk("fault_pp1", 64'(fwd_ppaddr[5:3]), 7);
    tick;

    // snoop relay
    cmd_retry = 1'b1; sack_retry = 1'b1;
    snoop_valid = 1'b1; snoop_hpaddr = 11'h2A;
    #1 chk("snp_idle_retry", 64'(snoop_retry), 0);
    tick;
    snoop_valid = 1'b0;
    chk("snp_cmd_valid", 64'(cmd_valid), 1);
    chk("snp_cmd_hp", 64'(cmd_hpaddr), 64'h2A);
    chk("snp_busy", 64'(snoop_retry), 1);
    tick;
    chk("snp_cmd_held", 64'(cmd_valid), 1);
    tick;
    cmd_retry = 1'b0;
    chk("snp_cmd_held2", 64'({cmd_valid, sack_valid}), 64'h2);
    tick;
    chk("snp_sack_valid", 64'({cmd_valid, sack_valid}), 64'h1);
    chk("snp_sack_hp", 64'(sack_hpaddr), 64'h2A);
    chk("snp_sack_busy", 64'(snoop_retry), 1);
    tick;
    chk("snp_sack_held", 64'(sack_valid), 1);
    sack_retry = 1'b0;
    tick;
    chk("snp_back_idle", 64'({snoop_retry, sack_valid, cmd_valid}), 0);

    // second snoop, reset while in SACK with a queued request
    sack_retry = 1'b1;
    snoop_valid = 1'b1; snoop_hpaddr = 11'h15;
    tick;
    snoop_valid = 1'b0;
    chk("snp2_cmd_hp", 64'(cmd_hpaddr), 64'h15);
    fwd_retry = 2'b10; core_valid = 2'b10; core_laddr[77:39] = 39'h1000;
    tick;
    core_valid = '0;
    chk("snp2_in_sack", 64'(sack_valid), 1);
    chk("snp2_queued", 64'(fwd_valid), 64'h2);
    reset = 1'b0;
    tick;
    reset = 1'b1;
    chk("mid_rst_valids", 64'({fwd_valid, cmd_valid, sack_valid}), 0);
    chk("mid_rst_retry", 64'({snoop_retry, core_retry}), 0);
    fwd_retry = '0; sack_retry = 1'b0;
    tick;
    chk("mid_rst_stays", 64'({fwd_valid, sack_valid}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
